// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bus joining two message requesters, the arbiter and the UART transmitter input.
interface uart_tx_arbiter_if;
  localparam int unsigned DATA_W = 8;

  logic [DATA_W-1:0] req0_data;
  logic              req0_valid;
  logic              req0_last;
  logic              req0_ready;
  logic [DATA_W-1:0] req1_data;
  logic              req1_valid;
  logic              req1_last;
  logic              req1_ready;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [1:0]        grant;
  logic              arb_timeout;

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    input  tx_ready,
    output req0_ready, req1_ready,
    output tx_data, tx_valid, grant, arb_timeout
  );

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    output tx_ready,
    input  req0_ready, req1_ready,
    input  tx_data, tx_valid, grant, arb_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a UART transmitter; holds the grant for a whole message.
// Optional forced release of a stalled lock is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic [1:0]        grant_q, grant_d;
  logic [DATA_W-1:0] tx_data_c;
  logic              tx_valid_c;
  logic              req0_ready_c;
  logic              req1_ready_c;
  logic              last_c;
  logic              xfer_c;
  logic              timeout_c;

  // The timeout counter is 16 bits wide, so the limit must fit in it.
  if (LOCK_TIMEOUT == 0 || LOCK_TIMEOUT > CNT_MAX) begin : g_bad_lock_timeout
    $error("uart_tx_arbiter: LOCK_TIMEOUT must be in 1..65535");
  end

  // Owner passthrough: data, valid and ready go straight through with no added latency.
  always_comb begin
    tx_data_c    = '0;
    tx_valid_c   = 1'b0;
    req0_ready_c = 1'b0;
    req1_ready_c = 1'b0;
    last_c       = 1'b0;
    case (state_q)
      LOCK0: begin
        tx_data_c    = bus.req0_data;
        tx_valid_c   = bus.req0_valid;
        req0_ready_c = bus.tx_ready;
        last_c       = bus.req0_last;
      end
      LOCK1: begin
        tx_data_c    = bus.req1_data;
        tx_valid_c   = bus.req1_valid;
        req1_ready_c = bus.tx_ready;
        last_c       = bus.req1_last;
      end
      default: ;
    endcase
  end

  assign xfer_c = tx_valid_c && bus.tx_ready;

  // Next state: IDLE always lasts one cycle, so consecutive messages get a one-cycle bubble.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (bus.req0_valid && (!bus.req1_valid || !ptr_q)) begin
          state_d = LOCK0;
        end else if (bus.req1_valid) begin
          state_d = LOCK1;
        end
      end
      LOCK0, LOCK1: begin
        if ((xfer_c && last_c) || timeout_c) begin
          state_d = IDLE;
          ptr_d   = (state_q == LOCK0);
        end
      end
      default: state_d = IDLE;
    endcase
    grant_d = {state_d == LOCK1, state_d == LOCK0};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      grant_q <= 2'b00;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             arb_timeout_q;

  // Counts locked cycles with no transfer; fires after exactly LOCK_TIMEOUT of them.
  always_comb begin
    timeout_c = (state_q != IDLE) && !xfer_c && (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
    cnt_d     = '0;
    if ((state_q != IDLE) && !xfer_c && !timeout_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q         <= '0;
      arb_timeout_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      arb_timeout_q <= timeout_c;
    end
  end

  assign bus.arb_timeout = arb_timeout_q;
`else
  assign timeout_c       = 1'b0;
  assign bus.arb_timeout = 1'b0;
`endif

  assign bus.tx_data    = tx_data_c;
  assign bus.tx_valid   = tx_valid_c;
  assign bus.req0_ready = req0_ready_c;
  assign bus.req1_ready = req1_ready_c;
  assign bus.grant      = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester drivers, expected-byte queue and a tx monitor.
module tb_uart_tx_arbiter;
  typedef struct {
    logic [7:0]  data;
    logic        last;
    int unsigned gap;
  } beat_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] grant;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset;
  int    tests = 0;
  int    fails = 0;
  beat_t q0[$];
  beat_t q1[$];
  exp_t  exp_q[$];

  uart_tx_arbiter_if bus ();

  uart_tx_arbiter #(.LOCK_TIMEOUT(16)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input int who, input logic [7:0] d, input logic l, input int unsigned gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = gap;
    if (who == 0) q0.push_back(b);
    else          q1.push_back(b);
  endtask

  task automatic expect_tx(input logic [7:0] d, input logic [1:0] g);
    exp_t e;
    e.data  = d;
    e.grant = g;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q0.size() + q1.size() + exp_q.size()) != 0 && n < 500) begin
      cyc(1);
      n++;
    end
    check({name, "_drain"}, 32'(q0.size() + q1.size() + exp_q.size()), 32'd0);
  endtask

  // Requester 0: present the head beat after its gap, retire it after a handshake.
  initial begin : drv0
    bit          ld;
    int unsigned g;
    logic        x;
    ld = 0;
    g  = 0;
    x  = 0;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req0_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (x && q0.size() > 0) begin
        q0.delete(0);
        ld = 0;
      end
      bus.req0_valid = 1'b0;
      if (q0.size() > 0) begin
        if (!ld) begin
          g  = q0[0].gap;
          ld = 1;
        end
        if (g > 0) g--;
        else begin
          bus.req0_valid = 1'b1;
          bus.req0_data  = q0[0].data;
          bus.req0_last  = q0[0].last;
        end
      end else ld = 0;
      #1;
      x = bus.req0_valid && bus.req0_ready && !reset;
    end
  end

  initial begin : drv1
    bit          ld;
    int unsigned g;
    logic        x;
    ld = 0;
    g  = 0;
    x  = 0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.req1_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (x && q1.size() > 0) begin
        q1.delete(0);
        ld = 0;
      end
      bus.req1_valid = 1'b0;
      if (q1.size() > 0) begin
        if (!ld) begin
          g  = q1[0].gap;
          ld = 1;
        end
        if (g > 0) g--;
        else begin
          bus.req1_valid = 1'b1;
          bus.req1_data  = q1[0].data;
          bus.req1_last  = q1[0].last;
        end
      end else ld = 0;
      #1;
      x = bus.req1_valid && bus.req1_ready && !reset;
    end
  end

  // Monitor: pops one expected byte per tx handshake and checks per-cycle output rules.
  initial begin : mon
    exp_t e;
    logic rel_pend;
    rel_pend = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) rel_pend = 1'b0;
      else begin
        if (rel_pend) check("bubble_after_last", 32'(bus.grant), 32'd0);
        rel_pend = 1'b0;
        if (bus.tx_valid && bus.tx_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL tx_unexpected: got byte %0h, expected nothing at %0t", bus.tx_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", 32'(bus.tx_data), 32'(e.data));
            check("tx_grant", 32'(bus.grant), 32'(e.grant));
          end
          rel_pend = (bus.grant == 2'b01) ? bus.req0_last :
                     (bus.grant == 2'b10) ? bus.req1_last : 1'b0;
        end
        case (bus.grant)
          2'b01: check("ready_lock0", 32'({bus.req0_ready, bus.req1_ready}), 32'({bus.tx_ready, 1'b0}));
          2'b10: check("ready_lock1", 32'({bus.req0_ready, bus.req1_ready}), 32'({1'b0, bus.tx_ready}));
          2'b00: check("idle_outputs",
                       32'({bus.tx_valid, bus.req0_ready, bus.req1_ready, bus.tx_data}), 32'd0);
          default: check("grant_onehot", 32'(bus.grant), 32'd1);
        endcase
`ifndef UART_TX_ARB_TIMEOUT_EN
        check("arb_timeout_off", 32'(bus.arb_timeout), 32'd0);
`endif
      end
    end
  end

  initial begin : main
    reset        = 1'b1;
    bus.tx_ready = 1'b1;

    // "ab" from req0, queued while reset holds the arbiter idle
    push(0, 8'h61, 1'b0, 0);
    push(0, 8'h62, 1'b1, 0);
    expect_tx(8'h61, 2'b01);
    expect_tx(8'h62, 2'b01);
    cyc(2);
    check("rst_grant", 32'(bus.grant), 32'd0);
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    check("rst_arb_timeout", 32'(bus.arb_timeout), 32'd0);
    reset = 1'b0;
    cyc(1);
    check("ab_grant_first", 32'(bus.grant), 32'd1);
    cyc(1);
    check("ab_grant_second", 32'(bus.grant), 32'd1);
    cyc(1);
    check("ab_grant_release", 32'(bus.grant), 32'd0);
    drain("ab");

    // Simultaneous requests after reset, req0 re-raises at once, then both contend again
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    push(0, 8'h78, 1'b0, 0);
    push(0, 8'h79, 1'b1, 0);
    push(0, 8'h70, 1'b0, 0);
    push(0, 8'h71, 1'b1, 0);
    push(1, 8'h31, 1'b0, 0);
    push(1, 8'h32, 1'b1, 0);
    push(1, 8'h33, 1'b1, 0);
    expect_tx(8'h78, 2'b01);
    expect_tx(8'h79, 2'b01);
    expect_tx(8'h31, 2'b10);
    expect_tx(8'h32, 2'b10);
    expect_tx(8'h70, 2'b01);
    expect_tx(8'h71, 2'b01);
    expect_tx(8'h33, 2'b10);
    drain("round_robin");

    // req1 three-byte message while req0 waits
    push(1, 8'h41, 1'b0, 0);
    push(1, 8'h42, 1'b0, 0);
    push(1, 8'h43, 1'b1, 0);
    expect_tx(8'h41, 2'b10);
    expect_tx(8'h42, 2'b10);
    expect_tx(8'h43, 2'b10);
    cyc(1);
    push(0, 8'h5A, 1'b1, 0);
    expect_tx(8'h5A, 2'b01);
    drain("no_interleave");

    // Transmitter stall for 20 cycles between two bytes of one message
    push(0, 8'h6D, 1'b0, 0);
    push(0, 8'h6E, 1'b1, 0);
    expect_tx(8'h6D, 2'b01);
    expect_tx(8'h6E, 2'b01);
    cyc(2);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("stall_tx_valid", 32'(bus.tx_valid), 32'd1);
      check("stall_tx_data", 32'(bus.tx_data), 32'h6E);
      check("stall_req0_ready", 32'(bus.req0_ready), 32'd0);
    end
    bus.tx_ready = 1'b1;
    drain("stall");

    // req0 sends one non-last byte and goes quiet; req1 waits
    push(0, 8'h63, 1'b0, 0);
    expect_tx(8'h63, 2'b01);
    cyc(2);
    push(1, 8'h65, 1'b1, 0);
`ifdef UART_TX_ARB_TIMEOUT_EN
    expect_tx(8'h65, 2'b10);
`endif
    cyc(15);
    check("quiet_grant_15", 32'(bus.grant), 32'd1);
    check("quiet_timeout_15", 32'(bus.arb_timeout), 32'd0);
    cyc(1);
`ifdef UART_TX_ARB_TIMEOUT_EN
    check("timeout_pulse", 32'(bus.arb_timeout), 32'd1);
    check("timeout_grant", 32'(bus.grant), 32'd0);
    cyc(1);
    check("timeout_pulse_end", 32'(bus.arb_timeout), 32'd0);
    check("timeout_next_grant", 32'(bus.grant), 32'd2);
`else
    check("hold_grant_16", 32'(bus.grant), 32'd1);
    check("hold_timeout_16", 32'(bus.arb_timeout), 32'd0);
    cyc(1);
    check("hold_grant_17", 32'(bus.grant), 32'd1);
    push(0, 8'h64, 1'b1, 0);
    expect_tx(8'h64, 2'b01);
    expect_tx(8'h65, 2'b10);
`endif
    drain("quiet_lock");

    // Single-byte message, then reset in the middle of a req1 message
    push(0, 8'h6B, 1'b1, 0);
    expect_tx(8'h6B, 2'b01);
    drain("single_byte");
    push(1, 8'h46, 1'b0, 0);
    push(1, 8'h47, 1'b0, 0);
    push(1, 8'h48, 1'b1, 0);
    expect_tx(8'h46, 2'b10);
    cyc(2);
    check("mid_msg_grant", 32'(bus.grant), 32'd2);
    reset = 1'b1;
    cyc(1);
    check("mid_rst_grant", 32'(bus.grant), 32'd0);
    check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    q1.delete();
    reset = 1'b0;
    push(0, 8'h72, 1'b1, 0);
    push(1, 8'h73, 1'b1, 0);
    expect_tx(8'h72, 2'b01);
    expect_tx(8'h73, 2'b10);
    drain("after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
